// File: rtl/ws2812_pkg.sv
// Shared types and default timing values for the WS2812 line encoder.
package ws2812_pkg;

  // Bit-encoder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Default bit timings in 64 MHz clocks.
  localparam int T0H_CNT  = 26;   // 406 ns
  localparam int T1H_CNT  = 51;   // 797 ns
  localparam int TBIT_CNT = 80;   // 1.25 us

  // Default reset-code length for the frame controller (60 us at 64 MHz).
  localparam int RST_CNT  = 3840;

endpackage

// File: rtl/ws2812_bit.sv
// WS2812 single-bit encoder: one accepted bit becomes a high pulse of th
// clocks followed by tl clocks low, then a one-cycle done strobe.
module ws2812_bit
  import ws2812_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 bit_rdy_in,
  input  logic                 bit_data_in,
  input  logic [CNT_WIDTH-1:0] t0h_cnt_in,
  input  logic [CNT_WIDTH-1:0] t1h_cnt_in,
  input  logic [CNT_WIDTH-1:0] tbit_cnt_in,
  output logic                 bit_done_out,
  output logic                 bit_err_out,
  output logic                 dout_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_tl, w_tl_nxt;
  logic                 r_dout, w_dout_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;

  logic [CNT_WIDTH-1:0] w_th_raw, w_th, w_tl;
  logic [CNT_WIDTH:0]   w_diff;

  // Phase lengths for the bit on offer; never zero, and the extra sign bit
  // of the subtraction catches a period shorter than the high time.
  always_comb begin
    w_th_raw = bit_data_in ? t1h_cnt_in : t0h_cnt_in;
    w_th     = (w_th_raw == '0) ? CNT_ONE : w_th_raw;
    w_diff   = {1'b0, tbit_cnt_in} - {1'b0, w_th};
    w_tl     = (w_diff[CNT_WIDTH] || (w_diff == '0)) ? CNT_ONE
                                                      : w_diff[CNT_WIDTH-1:0];
  end

  // Next-state and next-output logic; every register's next value is
  // computed here so all outputs leave the block registered.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tl_nxt    = r_tl;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_dout_nxt = 1'b0;
        if (bit_rdy_in) begin
          w_state_nxt = HIGH;
          w_dout_nxt  = 1'b1;
          w_cnt_nxt   = w_th - CNT_ONE;
          w_tl_nxt    = w_tl;   // timing frozen for the rest of the bit
        end
      end

      HIGH: begin
        w_err_nxt = bit_rdy_in;
        if (r_cnt == '0) begin
          w_state_nxt = LOW;
          w_dout_nxt  = 1'b0;
          w_cnt_nxt   = r_tl - CNT_ONE;
          w_done_nxt  = (r_tl == CNT_ONE);  // one-cycle low phase is also the last
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      LOW: begin
        w_err_nxt = bit_rdy_in;  // includes a request during the done cycle
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt  = r_cnt - CNT_ONE;
          w_done_nxt = (r_cnt == CNT_ONE);  // next cycle is the last low one
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_dout_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers; reset drops the line low immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tl    <= '0;
      r_dout  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tl    <= w_tl_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign dout_out     = r_dout;
  assign bit_done_out = r_done;
  assign bit_err_out  = r_err;

endmodule

// File: tb/tb_ws2812_bit.sv
// Directed bench for the WS2812 bit encoder: measures the high/low widths,
// done and error strobe timing of each bit against hand-computed values.
module tb_ws2812_bit;
  import ws2812_pkg::*;

  logic       clk_in;
  logic       rst_in;
  logic       bit_rdy_in;
  logic       bit_data_in;
  logic [7:0] t0h_cnt_in;
  logic [7:0] t1h_cnt_in;
  logic [7:0] tbit_cnt_in;
  logic       bit_done_out;
  logic       bit_err_out;
  logic       dout_out;

  ws2812_bit #(.CNT_WIDTH(8)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .bit_rdy_in   (bit_rdy_in),
    .bit_data_in  (bit_data_in),
    .t0h_cnt_in   (t0h_cnt_in),
    .t1h_cnt_in   (t1h_cnt_in),
    .tbit_cnt_in  (tbit_cnt_in),
    .bit_done_out (bit_done_out),
    .bit_err_out  (bit_err_out),
    .dout_out     (dout_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Per-bit measurements filled by run_bit.
  int m_hi, m_lo, m_done_at, m_dones, m_errs, m_err_at;
  int m_shape_err, m_tail_hi, m_accept_cyc;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one bit the cycle after the call, then watch the line until the
  // done strobe (bounded), plus 'tail' extra cycles. busy_at>0 raises
  // bit_rdy_in again in that cycle of the bit; scramble changes the timing
  // inputs right after the accept edge.
  task automatic run_bit(input logic d, input int busy_at, input int tail,
                         input bit scramble);
    logic [7:0] s0, s1, sb;
    bit seen_zero;
    bit done_seen;
    int c;
    s0 = t0h_cnt_in; s1 = t1h_cnt_in; sb = tbit_cnt_in;
    m_hi = 0; m_lo = 0; m_done_at = -1; m_dones = 0; m_errs = 0;
    m_err_at = -1; m_shape_err = 0; m_tail_hi = 0;
    seen_zero = 1'b0; done_seen = 1'b0; c = 0;

    @(negedge clk_in);
    bit_data_in = d;
    bit_rdy_in  = 1'b1;
    while (!done_seen && c < 400) begin
      @(negedge clk_in);
      c++;
      if (c == 1) begin
        m_accept_cyc = cyc;
        if (scramble) begin
          t0h_cnt_in = 8'd3; t1h_cnt_in = 8'd200; tbit_cnt_in = 8'd7;
        end
      end
      bit_rdy_in = (c == busy_at);
      if (dout_out) begin
        if (seen_zero) m_shape_err++;
        m_hi++;
      end else begin
        seen_zero = 1'b1;
        m_lo++;
      end
      if (bit_err_out) begin m_errs++; m_err_at = c; end
      if (bit_done_out) begin m_dones++; m_done_at = c; done_seen = 1'b1; end
    end
    for (int t = 0; t < tail; t++) begin
      @(negedge clk_in);
      c++;
      bit_rdy_in = (c == busy_at);
      if (dout_out)     m_tail_hi++;
      if (bit_done_out) m_dones++;
      if (bit_err_out)  begin m_errs++; m_err_at = c; end
    end
    t0h_cnt_in = s0; t1h_cnt_in = s1; tbit_cnt_in = sb;
  endtask

  initial begin
    logic [23:0] pat;
    int prev_acc;
    int b2b_dones;
    int idle_hits;

    rst_in      = 1'b1;
    bit_rdy_in  = 1'b0;
    bit_data_in = 1'b0;
    t0h_cnt_in  = 8'(T0H_CNT);
    t1h_cnt_in  = 8'(T1H_CNT);
    tbit_cnt_in = 8'(TBIT_CNT);

    // Reset state.
    repeat (3) @(negedge clk_in);
    check("rst_dout", int'(dout_out), 0);
    check("rst_done", int'(bit_done_out), 0);
    check("rst_err",  int'(bit_err_out), 0);
    rst_in = 1'b0;

    // Idle line stays low with no strobes.
    idle_hits = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (dout_out || bit_done_out || bit_err_out) idle_hits++;
    end
    check("idle_quiet", idle_hits, 0);

    // Single '0' at 26/51/80.
    run_bit(1'b0, 0, 3, 1'b0);
    check("zero_hi",    m_hi, 26);
    check("zero_lo",    m_lo, 54);
    check("zero_done",  m_done_at, 80);
    check("zero_ndone", m_dones, 1);
    check("zero_err",   m_errs, 0);
    check("zero_shape", m_shape_err + m_tail_hi, 0);

    // Single '1', timing inputs changed mid-bit must not matter.
    run_bit(1'b1, 0, 3, 1'b1);
    check("one_hi",    m_hi, 51);
    check("one_lo",    m_lo, 29);
    check("one_done",  m_done_at, 80);
    check("one_ndone", m_dones, 1);
    check("one_shape", m_shape_err + m_tail_hi, 0);

    // Back-to-back 0xA5C30F, MSB first, next request one cycle after done.
    pat = 24'hA5C30F;
    b2b_dones = 0;
    prev_acc = 0;
    for (int i = 0; i < 24; i++) begin
      run_bit(pat[23-i], 0, 0, 1'b0);
      b2b_dones += m_dones;
      check($sformatf("b2b_hi[%0d]", i), m_hi, pat[23-i] ? 51 : 26);
      check($sformatf("b2b_done[%0d]", i), m_done_at, 80);
      if (i > 0) check($sformatf("b2b_period[%0d]", i), m_accept_cyc - prev_acc, 81);
      prev_acc = m_accept_cyc;
    end
    check("b2b_ndone", b2b_dones, 24);
    repeat (3) @(negedge clk_in);

    // Clamp: zero high time becomes one cycle.
    t0h_cnt_in = 8'd0;
    run_bit(1'b0, 0, 3, 1'b0);
    check("clamp0_hi",   m_hi, 1);
    check("clamp0_lo",   m_lo, 79);
    check("clamp0_done", m_done_at, 80);
    t0h_cnt_in = 8'(T0H_CNT);

    // Clamp: high time beyond the period leaves a one-cycle low.
    t1h_cnt_in = 8'd90;
    run_bit(1'b1, 0, 3, 1'b0);
    check("clamp1_hi",    m_hi, 90);
    check("clamp1_lo",    m_lo, 1);
    check("clamp1_done",  m_done_at, 91);
    check("clamp1_ndone", m_dones, 1);
    check("clamp1_tail",  m_tail_hi, 0);
    t1h_cnt_in = 8'(T1H_CNT);

    // Clamp boundary: period equal to high time.
    t0h_cnt_in = 8'd80;
    run_bit(1'b0, 0, 3, 1'b0);
    check("clampeq_hi",   m_hi, 80);
    check("clampeq_lo",   m_lo, 1);
    check("clampeq_done", m_done_at, 81);
    t0h_cnt_in = 8'(T0H_CNT);

    // Busy request during the high phase.
    run_bit(1'b0, 10, 3, 1'b0);
    check("busy_err_at", m_err_at, 11);
    check("busy_nerr",   m_errs, 1);
    check("busy_hi",     m_hi, 26);
    check("busy_lo",     m_lo, 54);
    check("busy_ndone",  m_dones, 1);
    check("busy_tail",   m_tail_hi, 0);

    // Request in the same cycle as done is busy and dropped.
    run_bit(1'b1, 80, 4, 1'b0);
    check("coll_err_at", m_err_at, 81);
    check("coll_ndone",  m_dones, 1);
    check("coll_tail",   m_tail_hi, 0);

    // Reset in the middle of the high phase.
    @(negedge clk_in);
    bit_data_in = 1'b0;
    bit_rdy_in  = 1'b1;
    @(negedge clk_in);
    bit_rdy_in  = 1'b0;
    repeat (9) @(negedge clk_in);
    check("rstmid_pre", int'(dout_out), 1);
    #2 rst_in = 1'b1;
    #1 check("rstmid_async", int'(dout_out), 0);
    idle_hits = 0;
    repeat (3) begin
      @(negedge clk_in);
      if (dout_out || bit_done_out) idle_hits++;
    end
    rst_in = 1'b0;
    repeat (100) begin
      @(negedge clk_in);
      if (dout_out || bit_done_out || bit_err_out) idle_hits++;
    end
    check("rstmid_quiet", idle_hits, 0);

    run_bit(1'b1, 0, 3, 1'b0);
    check("post_hi",    m_hi, 51);
    check("post_lo",    m_lo, 29);
    check("post_done",  m_done_at, 80);
    check("post_ndone", m_dones, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
